fwd_hazard_unit: RTL and testbench
==================================

Name: fwd_hazard_unit

Overview:
- Parametrised forwarding and hazard unit for the pipelined MIPS core; successor to the fixed 2-source, 2-stage forwarding logic.
- Keeps a registered shadow of all in-flight register writes from EX through the last write-back stage.
- Produces per-operand forward selects for the EX-stage instruction and load-use stall/bubble control for ID.
- Sits beside the ID/EX, EX/MEM, MEM/WB pipeline registers; the datapath muxes consume fwd_sel.

Parameters:
AW, 5, register address width (register 0 hard-wired zero, never forwarded or stalled on)
STAGES, 3, number of forwarding sources after EX (1 = EX/MEM, 2 = MEM/WB, 3 = WB/late), legal 2..7
NSRC, 2, source operands per instruction, legal 1..3
LOAD_LAT, 2, shadow index at which load data first becomes forwardable, legal 1..STAGES
SW, 3, fwd_sel field width, must satisfy 2^SW > STAGES

Ports:
clk  in  1  core clock, all state on rising edge
reset  in  1  asynchronous, active-high; clears all shadow state
id_valid  in  1  ID holds a real instruction
id_src  in  NSRC*AW  ID source register numbers, operand i at [i*AW +: AW]
id_dest  in  AW  ID destination register
id_we  in  1  ID instruction writes the register file
id_is_load  in  1  ID instruction is a load
hold  in  1  external pipeline freeze (e.g. memory wait)
flush  in  1  kill ID and EX instructions (branch/exception)
fwd_sel  out  NSRC*SW  per-operand forward source for EX instruction: 0 = register file, k = shadow entry k
stall_id  out  1  hold PC and IF/ID this cycle (load-use)
bubble_ex  out  1  ID/EX must load a NOP this cycle

Behaviour:
- Shadow: entries 0..STAGES; entry 0 = EX instruction, entry k = k stages beyond EX. Each entry holds valid, dest, we, is_load, plus srcs for entry 0.
- Reset: all valid = 0; fwd_sel = 0, stall_id = 0, bubble_ex = 0 immediately and while reset is high.
- advance = !hold. On an advance edge, entry k+1 <= entry k for k = 0..STAGES-1. The old entry STAGES is dropped: the register file holds the value by then, via write-before-read.
- Entry 0 on an advance edge:
  - flush or stall_id: invalid (bubble).
  - otherwise: {id_valid, id_dest, id_src, id_we, id_is_load}.
- hold = 1: no entry changes, except flush still invalidates entry 0. Older entries are untouched (already committed).
- Producer match for entry k: valid && we && dest != 0 && dest == src.
- Forwardable when k >= 1 and (!is_load || k >= LOAD_LAT).
- fwd_sel[i]: the smallest k (youngest) whose entry matches entry-0 operand i and is forwardable, else 0. Combinational from registered state only. Operand i with src = 0 always gives 0.
- stall_id = id_valid && !flush, and some operand j has id_src[j] != 0 matching a valid load entry k with k <= LOAD_LAT-2. With LOAD_LAT = 1 it is never asserted.
- Stall length is LOAD_LAT-1-k cycles, re-evaluated every cycle.
- bubble_ex = (stall_id || flush) && !hold.
- Simultaneous events:
  - hold and stall_id: stall_id still reported; bubble_ex = 0.
  - flush and stall_id: stall_id = 0 (killed instruction stalls nothing).
- Reset asserted mid-stall: state clears asynchronously; the first cycle after release has no stall.

Optional Feature:
- Macro FWD_HAZARD_STALL_CNT_EN.
- Defined:
  - Extra output port stall_cnt (out, 16): saturating count of cycles with stall_id = 1 and hold = 0.
  - Cleared by reset; holds at 16'hFFFF.
  - Updates on the same edge as the shadow.
- Undefined: no port, no counter logic.

Test Plan:
- Reset then add $3 = $1+$2; sub $4 = $3-$5 back to back -> 2nd in EX: fwd_sel op0 = 1, op1 = 0; no stall.
- lw $8; unrelated; add $9 = $8+$8 (LOAD_LAT = 2) -> no stall; add in EX: both fwd_sel = 2.
- lw $8; add $9 = $8+$0 -> stall_id = 1 and bubble_ex = 1 for exactly 1 cycle; then fwd_sel op0 = 2, op1 = 0.
- Same as previous with hold = 1 for 3 cycles during the stall:
  - stall_id stays 1, bubble_ex = 0 while held, shadow frozen.
  - After release: one bubble, then forwarding from entry 2.
- add $3 in EX, flush asserted with ID reading $3 -> no stall, entry 0 invalid next cycle; the flushed add still forwards from entry 1.
- $3 written at entries 1 and 3 simultaneously -> fwd_sel = 1 (youngest); writes to $0 never forward (fwd_sel = 0).

Source files
------------

// File: rtl/fwd_hazard_unit.sv
// Forwarding and load-use hazard unit: keeps a shadow of in-flight register writes
// (EX through the last forwarding stage). Define FWD_HAZARD_STALL_CNT_EN to add stall_cnt.
module fwd_hazard_unit #(
  parameter int AW       = 5,
  parameter int STAGES   = 3,
  parameter int NSRC     = 2,
  parameter int LOAD_LAT = 2,
  parameter int SW       = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 id_valid,
  input  logic [NSRC*AW-1:0]   id_src,
  input  logic [AW-1:0]        id_dest,
  input  logic                 id_we,
  input  logic                 id_is_load,
  input  logic                 hold,
  input  logic                 flush,
  output logic [NSRC*SW-1:0]   fwd_sel,
  output logic                 stall_id,
`ifdef FWD_HAZARD_STALL_CNT_EN
  output logic                 bubble_ex,
  output logic [15:0]          stall_cnt
`else
  output logic                 bubble_ex
`endif
);

  // Entry 0 is the EX instruction; entry k sits k stages beyond EX.
  logic [STAGES:0]      r_valid;
  logic [STAGES:0]      r_we;
  logic [STAGES:0]      r_ld;
  logic [AW-1:0]        r_dest [0:STAGES];
  logic [NSRC*AW-1:0]   r_src0;

  logic [NSRC*SW-1:0]   w_fwd_sel;
  logic                 w_hit;
  logic                 w_stall;
  logic                 w_kill;

  always_comb begin
    w_fwd_sel = '0;
    // Scan oldest to youngest so the youngest forwardable producer wins.
    for (int i = 0; i < NSRC; i++) begin
      for (int k = STAGES; k >= 1; k--) begin
        if (r_valid[k] && r_we[k] && (r_dest[k] != '0) &&
            (r_dest[k] == r_src0[i*AW +: AW]) &&
            (!r_ld[k] || (k >= LOAD_LAT))) begin
          w_fwd_sel[i*SW +: SW] = SW'(k);
        end
      end
    end
  end

  always_comb begin
    w_hit = 1'b0;
    // Only loads still too young to forward (k <= LOAD_LAT-2) force a stall.
    for (int j = 0; j < NSRC; j++) begin
      for (int k = 0; k < LOAD_LAT - 1; k++) begin
        if ((id_src[j*AW +: AW] != '0) && r_valid[k] && r_ld[k] &&
            (r_dest[k] == id_src[j*AW +: AW])) begin
          w_hit = 1'b1;
        end
      end
    end
  end

  assign w_stall   = !reset && id_valid && !flush && w_hit;
  assign w_kill    = flush || w_stall;
  assign stall_id  = w_stall;
  assign bubble_ex = !reset && (w_stall || flush) && !hold;
  assign fwd_sel   = reset ? '0 : w_fwd_sel;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid <= '0;
      r_we    <= '0;
      r_ld    <= '0;
      r_src0  <= '0;
      for (int k = 0; k <= STAGES; k++) r_dest[k] <= '0;
    end else if (!hold) begin
      for (int k = 1; k <= STAGES; k++) begin
        r_valid[k] <= r_valid[k-1];
        r_we[k]    <= r_we[k-1];
        r_ld[k]    <= r_ld[k-1];
        r_dest[k]  <= r_dest[k-1];
      end
      if (w_kill) begin
        r_valid[0] <= 1'b0;
        r_we[0]    <= 1'b0;
        r_ld[0]    <= 1'b0;
        r_dest[0]  <= '0;
        r_src0     <= '0;
      end else begin
        r_valid[0] <= id_valid;
        r_we[0]    <= id_we;
        r_ld[0]    <= id_is_load;
        r_dest[0]  <= id_dest;
        r_src0     <= id_src;
      end
    end else if (flush) begin
      // Frozen pipe: only the EX instruction can still be killed.
      r_valid[0] <= 1'b0;
      r_we[0]    <= 1'b0;
      r_ld[0]    <= 1'b0;
      r_dest[0]  <= '0;
      r_src0     <= '0;
    end
  end

`ifdef FWD_HAZARD_STALL_CNT_EN
  logic [15:0] r_stall_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall_cnt <= '0;
    end else if (w_stall && !hold && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Bench for fwd_hazard_unit: directed scenarios plus random traffic checked against
// a queue-based model of the in-flight instruction window.
module tb_fwd_hazard_unit;
  localparam int AW       = 5;
  localparam int STAGES   = 3;
  localparam int NSRC     = 2;
  localparam int LOAD_LAT = 2;
  localparam int SW       = 3;

  logic                clk = 1'b0;
  logic                reset;
  logic                id_valid;
  logic [NSRC*AW-1:0]  id_src;
  logic [AW-1:0]       id_dest;
  logic                id_we;
  logic                id_is_load;
  logic                hold;
  logic                flush;
  logic [NSRC*SW-1:0]  fwd_sel;
  logic                stall_id;
  logic                bubble_ex;
`ifdef FWD_HAZARD_STALL_CNT_EN
  logic [15:0]         stall_cnt;
`endif

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic               v;
    logic [AW-1:0]      d;
    logic               we;
    logic               ld;
    logic [NSRC*AW-1:0] s;
  } instr_t;

  // Front of the queue is the EX instruction; index = stages beyond EX.
  instr_t m_q[$];
  logic [15:0] m_cnt;

  fwd_hazard_unit #(
    .AW(AW), .STAGES(STAGES), .NSRC(NSRC), .LOAD_LAT(LOAD_LAT), .SW(SW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .id_valid(id_valid),
    .id_src(id_src),
    .id_dest(id_dest),
    .id_we(id_we),
    .id_is_load(id_is_load),
    .hold(hold),
    .flush(flush),
    .fwd_sel(fwd_sel),
    .stall_id(stall_id),
`ifdef FWD_HAZARD_STALL_CNT_EN
    .bubble_ex(bubble_ex),
    .stall_cnt(stall_cnt)
`else
    .bubble_ex(bubble_ex)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [SW-1:0] m_fwd(input int i);
    logic [AW-1:0] op;
    op = m_q[0].s[i*AW +: AW];
    if (op == '0) return '0;
    for (int age = 1; age <= STAGES; age++) begin
      if (m_q[age].v && m_q[age].we && m_q[age].d == op &&
          (!m_q[age].ld || age >= LOAD_LAT)) return SW'(age);
    end
    return '0;
  endfunction

  function automatic logic m_stall();
    logic [AW-1:0] s;
    if (!id_valid || flush) return 1'b0;
    for (int j = 0; j < NSRC; j++) begin
      s = id_src[j*AW +: AW];
      for (int age = 0; age <= LOAD_LAT - 2; age++) begin
        if (s != '0 && m_q[age].v && m_q[age].ld && m_q[age].d == s) return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  task automatic m_reset();
    m_q.delete();
    for (int k = 0; k <= STAGES; k++) m_q.push_back('0);
    m_cnt = '0;
  endtask

  task automatic drive(input logic v, input logic [AW-1:0] s0, input logic [AW-1:0] s1,
                       input logic [AW-1:0] d, input logic we, input logic ld,
                       input logic h, input logic f);
    @(negedge clk);
    id_valid = v; id_src = {s1, s0}; id_dest = d; id_we = we;
    id_is_load = ld; hold = h; flush = f;
    #1;
  endtask

  task automatic check_model();
    logic es;
    es = m_stall();
    for (int i = 0; i < NSRC; i++)
      chk($sformatf("fwd_op%0d", i), 16'(fwd_sel[i*SW +: SW]), 16'(m_fwd(i)));
    chk("stall", 16'(stall_id), 16'(es));
    chk("bubble", 16'(bubble_ex), 16'((es || flush) && !hold));
`ifdef FWD_HAZARD_STALL_CNT_EN
    chk("stall_cnt", stall_cnt, m_cnt);
`endif
  endtask

  task automatic tick();
    logic   s;
    instr_t rec;
    s = m_stall();
    @(posedge clk);
    if (!hold) begin
      rec = '0;
      if (!(flush || s)) begin
        rec.v = id_valid; rec.d = id_dest; rec.we = id_we;
        rec.ld = id_is_load; rec.s = id_src;
      end
      m_q.push_front(rec);
      void'(m_q.pop_back());
    end else if (flush) begin
      m_q[0] = '0;
    end
    if (s && !hold && m_cnt != 16'hFFFF) m_cnt++;
  endtask

  task automatic step(input logic v, input logic [AW-1:0] s0, input logic [AW-1:0] s1,
                      input logic [AW-1:0] d, input logic we, input logic ld,
                      input logic h, input logic f);
    drive(v, s0, s1, d, we, ld, h, f);
    check_model();
    tick();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    id_valid = 1'b1; id_src = {5'd3, 5'd3}; id_dest = 5'd3; id_we = 1'b1;
    id_is_load = 1'b0; hold = 1'b0; flush = 1'b1;
    #1;
    chk("rst_fwd", 16'(fwd_sel), 16'h0);
    chk("rst_stall", 16'(stall_id), 16'h0);
    chk("rst_bubble", 16'(bubble_ex), 16'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    id_valid = 1'b0; id_src = '0; id_dest = '0; id_we = 1'b0; flush = 1'b0;
    reset = 1'b0;
    m_reset();
  endtask

  initial begin
    reset = 1'b1;
    id_valid = 1'b0; id_src = '0; id_dest = '0; id_we = 1'b0;
    id_is_load = 1'b0; hold = 1'b0; flush = 1'b0;
    m_reset();

    // add $3=$1+$2 ; sub $4=$3-$5
    do_reset();
    step(1, 1, 2, 3, 1, 0, 0, 0);
    step(1, 3, 5, 4, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    check_model();
    chk("t1_op0", 16'(fwd_sel[SW-1:0]), 16'd1);
    chk("t1_op1", 16'(fwd_sel[2*SW-1:SW]), 16'd0);
    tick();

    // lw $8 ; unrelated ; add $9=$8+$8
    do_reset();
    step(1, 0, 0, 8, 1, 1, 0, 0);
    step(1, 1, 2, 10, 1, 0, 0, 0);
    drive(1, 8, 8, 9, 1, 0, 0, 0);
    check_model();
    chk("t2_nostall", 16'(stall_id), 16'd0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    check_model();
    chk("t2_op0", 16'(fwd_sel[SW-1:0]), 16'd2);
    chk("t2_op1", 16'(fwd_sel[2*SW-1:SW]), 16'd2);
    tick();

    // lw $8 ; add $9=$8+$0 -> one-cycle load-use stall
    do_reset();
    step(1, 0, 0, 8, 1, 1, 0, 0);
    drive(1, 8, 0, 9, 1, 0, 0, 0);
    check_model();
    chk("t3_stall", 16'(stall_id), 16'd1);
    chk("t3_bubble", 16'(bubble_ex), 16'd1);
    tick();
    drive(1, 8, 0, 9, 1, 0, 0, 0);
    check_model();
    chk("t3_release", 16'(stall_id), 16'd0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    check_model();
    chk("t3_op0", 16'(fwd_sel[SW-1:0]), 16'd2);
    chk("t3_op1", 16'(fwd_sel[2*SW-1:SW]), 16'd0);
    tick();

    // Same with hold during the stall
    do_reset();
    step(1, 0, 0, 8, 1, 1, 0, 0);
    for (int n = 0; n < 3; n++) begin
      drive(1, 8, 0, 9, 1, 0, 1, 0);
      check_model();
      chk("t4_hold_stall", 16'(stall_id), 16'd1);
      chk("t4_hold_bubble", 16'(bubble_ex), 16'd0);
      tick();
    end
    drive(1, 8, 0, 9, 1, 0, 0, 0);
    check_model();
    chk("t4_bubble", 16'(bubble_ex), 16'd1);
    tick();
    drive(1, 8, 0, 9, 1, 0, 0, 0);
    check_model();
    chk("t4_release", 16'(stall_id), 16'd0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    check_model();
    chk("t4_op0", 16'(fwd_sel[SW-1:0]), 16'd2);
    tick();

    // Flush with add $3 in EX and a $3 reader in ID
    do_reset();
    step(1, 1, 2, 3, 1, 0, 0, 0);
    drive(1, 3, 3, 6, 1, 0, 0, 1);
    check_model();
    chk("t5_nostall", 16'(stall_id), 16'd0);
    chk("t5_bubble", 16'(bubble_ex), 16'd1);
    tick();
    drive(1, 3, 0, 7, 1, 0, 0, 0);
    check_model();
    chk("t5_ex_invalid", 16'(fwd_sel), 16'd0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    check_model();
    chk("t5_fwd_flushed_add", 16'(fwd_sel[SW-1:0]), 16'd2);
    tick();

    // $3 written at entries 1 and 3; writes to $0 never forward
    do_reset();
    step(1, 1, 2, 3, 1, 0, 0, 0);
    step(1, 1, 2, 10, 1, 0, 0, 0);
    step(1, 4, 5, 3, 1, 0, 0, 0);
    step(1, 3, 3, 11, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    check_model();
    chk("t6_young_op0", 16'(fwd_sel[SW-1:0]), 16'd1);
    chk("t6_young_op1", 16'(fwd_sel[2*SW-1:SW]), 16'd1);
    tick();
    step(1, 1, 2, 0, 1, 0, 0, 0);
    step(1, 0, 0, 12, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    check_model();
    chk("t6_zero", 16'(fwd_sel), 16'd0);
    tick();

    // Reset asserted mid-stall
    do_reset();
    step(1, 0, 0, 8, 1, 1, 0, 0);
    drive(1, 8, 0, 9, 1, 0, 0, 0);
    chk("t7_pre_stall", 16'(stall_id), 16'd1);
    #2 reset = 1'b1;
    #1;
    chk("t7_rst_stall", 16'(stall_id), 16'd0);
    chk("t7_rst_bubble", 16'(bubble_ex), 16'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    m_reset();
    #1;
    check_model();
    chk("t7_post_stall", 16'(stall_id), 16'd0);
    tick();

    // Random traffic
    do_reset();
    for (int n = 0; n < 400; n++) begin
      step(($urandom_range(0, 7) != 0),
           AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)),
           AW'($urandom_range(0, 7)),
           ($urandom_range(0, 5) != 0), ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 5) == 0), ($urandom_range(0, 7) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
